// File: rtl/voice_allocator_if.sv
// ============================================================================
// Module   : voice_allocator_if
// Brief    : Key-level input and voice-state outputs of the voice allocator.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface voice_allocator_if #(
    parameter int NUM_KEYS   = 16,
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = 4
);
    logic [NUM_KEYS-1:0]         key_held;
    logic [NUM_VOICES-1:0]       voice_en;
    logic [NUM_VOICES*KEY_W-1:0] voice_key;
    logic [NUM_VOICES-1:0]       voice_start;
    logic                        busy;

    modport master (
        output key_held,
        input  voice_en,
        input  voice_key,
        input  voice_start,
        input  busy
    );

    modport slave (
        input  key_held,
        output voice_en,
        output voice_key,
        output voice_start,
        output busy
    );
endinterface

`default_nettype wire

// File: rtl/voice_allocator.sv
// ============================================================================
// Module   : voice_allocator
// Brief    : Key edge detection, one-event-per-clock scheduling and
//            oldest-voice stealing over a shared oscillator bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

module voice_allocator #(
    parameter int NUM_KEYS   = 16,
    parameter int NUM_VOICES = 4,
    parameter int KEY_W      = $clog2(NUM_KEYS)
) (
    input  wire logic         clk,
    input  wire logic         nrst,
    voice_allocator_if.slave  bus
);

    localparam int RANK_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [RANK_W-1:0] C_OLDEST = RANK_W'(NUM_VOICES - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SERVE = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [NUM_KEYS-1:0]         r_key_q;
    logic [NUM_KEYS-1:0]         r_pend_press;
    logic [NUM_KEYS-1:0]         r_pend_rel;
    logic [NUM_VOICES-1:0]       r_voice_en;
    logic [NUM_VOICES*KEY_W-1:0] r_voice_key;
    logic [NUM_VOICES-1:0]       r_voice_start;
    logic [RANK_W-1:0]           r_rank [NUM_VOICES];

    logic [NUM_KEYS-1:0]         w_rise;
    logic [NUM_KEYS-1:0]         w_fall;
    logic [NUM_KEYS-1:0]         w_clr_press;
    logic [NUM_KEYS-1:0]         w_clr_rel;
    logic [NUM_KEYS-1:0]         w_press_nxt;
    logic [NUM_KEYS-1:0]         w_rel_nxt;
    logic [KEY_W-1:0]            w_rel_idx;
    logic [KEY_W-1:0]            w_press_idx;
    logic [KEY_W-1:0]            w_ev_key;
    logic                        w_serve_rel;
    logic                        w_serve_press;
    logic                        w_free_any;
    logic [RANK_W-1:0]           w_free_idx;
    logic [RANK_W-1:0]           w_steal_idx;
    logic [RANK_W-1:0]           w_tgt;
    logic [RANK_W-1:0]           w_tgt_rank;

    assign w_rise = bus.key_held & ~r_key_q;
    assign w_fall = ~bus.key_held & r_key_q;

    // Lowest-index pending events; the descending loop lets the lowest index win.
    always_comb begin
        w_rel_idx   = '0;
        w_press_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (r_pend_rel[i])   w_rel_idx   = KEY_W'(i);
            if (r_pend_press[i]) w_press_idx = KEY_W'(i);
        end
    end

    // Free-voice search and steal candidate (the voice holding the oldest rank).
    always_comb begin
        w_free_any  = 1'b0;
        w_free_idx  = '0;
        w_steal_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!r_voice_en[v]) begin
                w_free_any = 1'b1;
                w_free_idx = RANK_W'(v);
            end
            if (r_rank[v] == C_OLDEST) w_steal_idx = RANK_W'(v);
        end
        w_tgt      = w_free_any ? w_free_idx : w_steal_idx;
        w_tgt_rank = r_rank[w_tgt];
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Serve decode and pending-set update. A fresh edge overrides the bit just served.
    always_comb begin
        w_serve_rel   = 1'b0;
        w_serve_press = 1'b0;
        w_ev_key      = w_press_idx;
        w_clr_rel     = '0;
        w_clr_press   = '0;
        if (r_state == S_SERVE) begin
            if (|r_pend_rel) begin
                w_serve_rel = 1'b1;
                w_ev_key    = w_rel_idx;
                w_clr_rel   = NUM_KEYS'(1) << w_rel_idx;
            end else if (|r_pend_press) begin
                w_serve_press = 1'b1;
                w_clr_press   = NUM_KEYS'(1) << w_press_idx;
            end
        end
        w_press_nxt = ((r_pend_press & ~w_clr_press) | w_rise) & ~w_fall;
        w_rel_nxt   = ((r_pend_rel   & ~w_clr_rel)   | w_fall) & ~w_rise;
        w_state_nxt = ((|w_press_nxt) || (|w_rel_nxt)) ? S_SERVE : S_IDLE;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_key_q       <= '0;
            r_pend_press  <= '0;
            r_pend_rel    <= '0;
            r_voice_en    <= '0;
            r_voice_key   <= '0;
            r_voice_start <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_rank[v] <= RANK_W'(v);
            end
        end else begin
            r_key_q       <= bus.key_held;
            r_pend_press  <= w_press_nxt;
            r_pend_rel    <= w_rel_nxt;
            r_voice_start <= '0;
            if (w_serve_rel) begin
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (r_voice_en[v] && (r_voice_key[v*KEY_W +: KEY_W] == w_ev_key)) begin
                        r_voice_en[v] <= 1'b0;
                    end
                end
            end
            if (w_serve_press) begin
                r_voice_en[w_tgt]                       <= 1'b1;
                r_voice_key[int'(w_tgt)*KEY_W +: KEY_W] <= w_ev_key;
                r_voice_start[w_tgt]                    <= 1'b1;
                // Target's own rank never satisfies the compare, so the final write is unambiguous.
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (r_rank[v] < w_tgt_rank) r_rank[v] <= r_rank[v] + 1'b1;
                end
                r_rank[w_tgt] <= '0;
            end
        end
    end

    assign bus.voice_en    = r_voice_en;
    assign bus.voice_key   = r_voice_key;
    assign bus.voice_start = r_voice_start;
    assign bus.busy        = (r_state == S_SERVE);

endmodule

`default_nettype wire

// File: tb/tb_voice_allocator.sv
// ============================================================================
// Module   : tb_voice_allocator
// Brief    : Directed scenarios plus random key traffic against an event-queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_voice_allocator;

    localparam int NK = 16;
    localparam int NV = 4;
    localparam int KW = 4;

    logic clk  = 1'b0;
    logic nrst = 1'b0;

    voice_allocator_if #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW)) bus ();

    voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV), .KEY_W(KW)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pending sets, voice table, and an age list (newest first).
    bit m_en    [NV];
    int m_key   [NV];
    bit m_start [NV];
    bit m_pp    [NK];
    bit m_pr    [NK];
    bit m_prev  [NK];
    bit m_busy;
    int age_q   [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int v = 0; v < NV; v++) begin
            m_en[v] = 1'b0; m_key[v] = 0; m_start[v] = 1'b0;
        end
        for (int k = 0; k < NK; k++) begin
            m_pp[k] = 1'b0; m_pr[k] = 1'b0; m_prev[k] = 1'b0;
        end
        m_busy = 1'b0;
        age_q.delete();
        for (int v = 0; v < NV; v++) age_q.push_back(v);
    endtask

    task automatic m_step(input logic [NK-1:0] held);
        int k;
        int t;
        bit any;
        k = -1;
        for (int v = 0; v < NV; v++) m_start[v] = 1'b0;
        for (int i = NK - 1; i >= 0; i--) if (m_pr[i]) k = i;
        if (k >= 0) begin
            m_pr[k] = 1'b0;
            for (int v = 0; v < NV; v++) if (m_en[v] && m_key[v] == k) m_en[v] = 1'b0;
        end else begin
            for (int i = NK - 1; i >= 0; i--) if (m_pp[i]) k = i;
            if (k >= 0) begin
                m_pp[k] = 1'b0;
                t = -1;
                for (int v = NV - 1; v >= 0; v--) if (!m_en[v]) t = v;
                if (t < 0) t = age_q[$];
                m_en[t] = 1'b1; m_key[t] = k; m_start[t] = 1'b1;
                for (int i = 0; i < age_q.size(); i++) begin
                    if (age_q[i] == t) begin
                        age_q.delete(i);
                        break;
                    end
                end
                age_q.push_front(t);
            end
        end
        any = 1'b0;
        for (int i = 0; i < NK; i++) begin
            if (held[i] && !m_prev[i]) begin m_pp[i] = 1'b1; m_pr[i] = 1'b0; end
            if (!held[i] && m_prev[i]) begin m_pr[i] = 1'b1; m_pp[i] = 1'b0; end
            m_prev[i] = held[i];
            any = any | m_pp[i] | m_pr[i];
        end
        m_busy = any;
    endtask

    task automatic compare_all(input string where);
        logic [NV-1:0]    e_en;
        logic [NV-1:0]    e_st;
        logic [NV*KW-1:0] e_key;
        for (int v = 0; v < NV; v++) begin
            e_en[v]            = m_en[v];
            e_st[v]            = m_start[v];
            e_key[v*KW +: KW]  = KW'(m_key[v]);
        end
        check({where, "_en"},    64'(bus.voice_en),    64'(e_en));
        check({where, "_key"},   64'(bus.voice_key),   64'(e_key));
        check({where, "_start"}, 64'(bus.voice_start), 64'(e_st));
        check({where, "_busy"},  64'(bus.busy),        64'(m_busy));
    endtask

    task automatic cyc(input logic [NK-1:0] keys, input string where);
        bus.key_held = keys;
        @(posedge clk);
        m_step(keys);
        #1;
        compare_all(where);
    endtask

    function automatic logic [NK-1:0] kb(input int k);
        logic [NK-1:0] one;
        one = NK'(1);
        return one << k;
    endfunction

    logic [NK-1:0] keys;

    initial begin
        // Test 1: reset with keys 2 and 5 held.
        keys = kb(2) | kb(5);
        bus.key_held = keys;
        nrst = 1'b0;
        m_reset();
        repeat (2) begin
            @(posedge clk); #1;
            compare_all("rst");
        end
        nrst = 1'b1;
        cyc(keys, "t1");
        cyc(keys, "t1");
        check("t1_en_after2",    64'(bus.voice_en),    64'h1);
        check("t1_start_after2", 64'(bus.voice_start), 64'h1);
        cyc(keys, "t1");
        check("t1_key5_v1", 64'(bus.voice_key[KW +: KW]), 64'd5);
        keys = '0;
        repeat (4) cyc(keys, "t1d");

        // Test 2: single press and release of key 3.
        keys = kb(3);
        cyc(keys, "t2");
        cyc(keys, "t2");
        check("t2_en",    64'(bus.voice_en),         64'h1);
        check("t2_key0",  64'(bus.voice_key[KW-1:0]), 64'd3);
        check("t2_start", 64'(bus.voice_start),      64'h1);
        cyc(keys, "t2");
        check("t2_start_drop", 64'(bus.voice_start), 64'h0);
        keys = '0;
        cyc(keys, "t2r");
        cyc(keys, "t2r");
        check("t2_released", 64'(bus.voice_en), 64'h0);
        repeat (2) cyc(keys, "t2d");

        // Test 3: three presses in one cycle, served one per clock.
        keys = kb(1) | kb(5) | kb(9);
        cyc(keys, "t3"); check("t3_busy", 64'(bus.busy), 64'h1);
        cyc(keys, "t3"); check("t3_s0", 64'(bus.voice_start), 64'h1);
        cyc(keys, "t3"); check("t3_s1", 64'(bus.voice_start), 64'h2);
        cyc(keys, "t3"); check("t3_s2", 64'(bus.voice_start), 64'h4);
        check("t3_idle", 64'(bus.busy), 64'h0);
        keys = '0;
        repeat (5) cyc(keys, "t3d");

        // Test 4: fill all voices, then steal the oldest for key 7.
        for (int k = 0; k < 4; k++) begin
            keys = keys | kb(k);
            repeat (4) cyc(keys, "t4");
        end
        keys = keys | kb(7);
        cyc(keys, "t4");
        cyc(keys, "t4");
        check("t4_steal_key", 64'(bus.voice_key[KW-1:0]), 64'd7);
        check("t4_steal_start", 64'(bus.voice_start), 64'h1);
        keys = keys & ~kb(0);
        repeat (3) cyc(keys, "t4r0");
        check("t4_rel0_noop", 64'(bus.voice_en), 64'hF);
        keys = keys & ~kb(7);
        repeat (3) cyc(keys, "t4r7");
        check("t4_rel7", 64'(bus.voice_en), 64'hE);

        // Test 5: simultaneous release of key 2 and press of key 8, no steal.
        keys = keys | kb(6);
        repeat (3) cyc(keys, "t5");
        check("t5_full", 64'(bus.voice_en), 64'hF);
        keys = (keys & ~kb(2)) | kb(8);
        repeat (3) cyc(keys, "t5x");
        check("t5_v2_key8", 64'(bus.voice_key[2*KW +: KW]), 64'd8);
        check("t5_v0_key6", 64'(bus.voice_key[KW-1:0]), 64'd6);
        check("t5_en", 64'(bus.voice_en), 64'hF);
        keys = '0;
        repeat (8) cyc(keys, "t5d");

        // Test 6: key 4 pressed and released behind three pending releases.
        keys = kb(10) | kb(11) | kb(12);
        repeat (5) cyc(keys, "t6");
        keys = kb(4);
        cyc(keys, "t6b");
        keys = '0;
        for (int i = 0; i < 6; i++) begin
            cyc(keys, "t6b");
            for (int v = 0; v < NV; v++) begin
                if (bus.voice_en[v]) check("t6_no_key4", 64'(bus.voice_key[v*KW +: KW] == KW'(4)), 64'h0);
            end
        end
        check("t6_idle", 64'(bus.busy), 64'h0);
        check("t6_en",   64'(bus.voice_en), 64'h0);

        // Random key traffic with occasional asynchronous reset.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 2) == 0) keys[$urandom_range(0, NK-1)] ^= 1'b1;
            if ($urandom_range(0, 9) == 0) keys[$urandom_range(0, 5)] ^= 1'b1;
            cyc(keys, "rnd");
            if ($urandom_range(0, 299) == 0) begin
                nrst = 1'b0;
                #1;
                m_reset();
                compare_all("rnd_rst");
                #2 nrst = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
